// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the control-unit step sequencer:
//   - fixed state numbers (fetch, decode, halt, interrupt)
//   - first execute step of every instruction and the default END_MASK that
//     marks the last execute step of each instruction
//   - opcode enumeration
// Execute-step layout (first..last):
//   NOP 3, INC 4, ADD 5-6, SUB 7-8, AND 9-10, OR 11-12, LOAD 13-15,
//   LDI 14-15 (shares the LOAD tail), STORE 16-18, JMP 19-20, JZ 21-22,
//   CALL 23-26, RET 27-29, MUL 30-37. HALT dispatches straight to state 38.
// -----------------------------------------------------------------------------
package cu_pkg;

  localparam int CU_N      = 6;
  localparam int CU_STATES = 40;
  localparam int CU_OPW    = 5;

  // Fixed state numbers
  localparam int S_FETCH0 = 0;
  localparam int S_FETCH1 = 1;
  localparam int S_DECODE = 2;
  localparam int S_HALT   = 38;
  localparam int S_IRQ    = 39;

  // First execute step of each instruction
  localparam int ST_NOP   = 3;
  localparam int ST_INC   = 4;
  localparam int ST_ADD   = 5;
  localparam int ST_SUB   = 7;
  localparam int ST_AND   = 9;
  localparam int ST_OR    = 11;
  localparam int ST_LOAD  = 13;
  localparam int ST_LDI   = 14;
  localparam int ST_STORE = 16;
  localparam int ST_JMP   = 19;
  localparam int ST_JZ    = 21;
  localparam int ST_CALL  = 23;
  localparam int ST_RET   = 27;
  localparam int ST_MUL   = 30;

  // Terminal execute steps: 3,4,6,8,10,12,15,18,20,22,26,29,37
  localparam logic [CU_STATES-1:0] END_MASK_DEFAULT = 40'h20_2454_9558;

  typedef enum logic [CU_OPW-1:0] {
    OP_NOP   = 5'd0,
    OP_INC   = 5'd1,
    OP_ADD   = 5'd2,
    OP_SUB   = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_LOAD  = 5'd6,
    OP_STORE = 5'd7,
    OP_JMP   = 5'd8,
    OP_JZ    = 5'd9,
    OP_CALL  = 5'd10,
    OP_RET   = 5'd11,
    OP_MUL   = 5'd12,
    OP_LDI   = 5'd13,
    OP_HALT  = 5'd14
  } opcode_e;

endpackage

// File: rtl/CU_decoder.sv
// -----------------------------------------------------------------------------
// CU_decoder
// One-hot decode of the sequencer state number.
// Ports:
//   counter_value in  N       current state number
//   CPU_state     out states  one-hot vector; all zeros for out-of-range counts
// -----------------------------------------------------------------------------
module CU_decoder #(
  parameter int N      = 6,
  parameter int states = 40
) (
  input  logic [N-1:0]      counter_value,
  output logic [states-1:0] CPU_state
);

  // Each output bit compares the counter against its own index.
  always_comb begin
    CPU_state = '0;
    for (int s = 0; s < states; s++) begin
      CPU_state[s] = (counter_value == N'(s));
    end
  end

endmodule

// File: rtl/cu_dispatch_rom.sv
// -----------------------------------------------------------------------------
// cu_dispatch_rom
// Combinational opcode dispatch table used in DECODE.
// Ports:
//   opcode      in  OPW  instruction opcode field
//   valid       out 1    opcode is mapped
//   start_state out N    first state after DECODE (3..38); 0 when unmapped
// -----------------------------------------------------------------------------
module cu_dispatch_rom
  import cu_pkg::*;
#(
  parameter int N   = CU_N,
  parameter int OPW = CU_OPW
) (
  input  logic [OPW-1:0] opcode,
  output logic           valid,
  output logic [N-1:0]   start_state
);

  // Opcode to first execute step; anything outside the enum is unmapped.
  always_comb begin
    valid       = 1'b1;
    start_state = N'(S_FETCH0);
    case (opcode)
      OP_NOP:   start_state = N'(ST_NOP);
      OP_INC:   start_state = N'(ST_INC);
      OP_ADD:   start_state = N'(ST_ADD);
      OP_SUB:   start_state = N'(ST_SUB);
      OP_AND:   start_state = N'(ST_AND);
      OP_OR:    start_state = N'(ST_OR);
      OP_LOAD:  start_state = N'(ST_LOAD);
      OP_STORE: start_state = N'(ST_STORE);
      OP_JMP:   start_state = N'(ST_JMP);
      OP_JZ:    start_state = N'(ST_JZ);
      OP_CALL:  start_state = N'(ST_CALL);
      OP_RET:   start_state = N'(ST_RET);
      OP_MUL:   start_state = N'(ST_MUL);
      OP_LDI:   start_state = N'(ST_LDI);
      OP_HALT:  start_state = N'(S_HALT);
      default: begin
        valid       = 1'b0;
        start_state = N'(S_FETCH0);
      end
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// -----------------------------------------------------------------------------
// cu_sequencer
// Control-unit step sequencer: FETCH0 -> FETCH1 -> DECODE -> execute steps ->
// FETCH0, with stall, HALT, illegal-opcode trapping and optional interrupt entry.
// Configuration macro: CU_IRQ_EN (defined: irq taken at instruction boundaries
// and in HALT via state 39; undefined: irq ignored, state 39 illegal,
// irq_ack always 0). Port list is the same in both builds.
// Ports:
//   clk           in  1       rising-edge clock
//   rst           in  1       synchronous active-high reset
//   stall         in  1       freezes the sequencer and all registered outputs
//   opcode        in  OPW     IR opcode, used only in DECODE
//   irq           in  1       level interrupt request
//   counter_value out N       registered state number
//   CPU_state     out states  one-hot decode of counter_value
//   instr_done    out 1       terminal execute step retiring this cycle
//   halted        out 1       in HALT
//   illegal_op    out 1       sticky illegal opcode / illegal state flag
//   irq_ack       out 1       in IRQ state
// -----------------------------------------------------------------------------
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int                N        = CU_N,
  parameter int                states   = CU_STATES,
  parameter int                OPW      = CU_OPW,
  parameter logic [states-1:0] END_MASK = END_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [OPW-1:0]    opcode,
  input  logic              irq,
  output logic [N-1:0]      counter_value,
  output logic [states-1:0] CPU_state,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal_op,
  output logic              irq_ack
);

  // One extra bit so a full 2**N state count still compares correctly.
  localparam logic [N:0] STATE_COUNT = (N+1)'(states);

  logic         rom_valid;
  logic [N-1:0] rom_start;
  logic [N-1:0] next_count;
  logic         set_illegal;
  logic         terminal;
  logic         irq_take;

`ifdef CU_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
  assign irq_take = irq;
`else
  localparam logic IRQ_ON = 1'b0;
  logic unused_irq;
  assign unused_irq = irq;
  assign irq_take   = 1'b0;
`endif

  cu_dispatch_rom #(
    .N   (N),
    .OPW (OPW)
  ) u_dispatch (
    .opcode      (opcode),
    .valid       (rom_valid),
    .start_state (rom_start)
  );

  CU_decoder #(
    .N      (N),
    .states (states)
  ) u_decoder (
    .counter_value (counter_value),
    .CPU_state     (CPU_state)
  );

  // Next-state selection; interrupt entry only where the next state would be FETCH0
  // after a retire, or from HALT.
  always_comb begin
    next_count  = counter_value;
    set_illegal = 1'b0;
    terminal    = 1'b0;
    if ({1'b0, counter_value} >= STATE_COUNT) begin
      // Corrupted counter (e.g. upset): recover to fetch and flag it
      next_count  = N'(S_FETCH0);
      set_illegal = 1'b1;
    end else begin
      case (counter_value)
        N'(S_FETCH0): next_count = N'(S_FETCH1);
        N'(S_FETCH1): next_count = N'(S_DECODE);
        N'(S_DECODE): begin
          if (rom_valid) begin
            next_count = rom_start;
          end else begin
            next_count  = N'(S_FETCH0);
            set_illegal = 1'b1;
          end
        end
        N'(S_HALT): begin
          if (irq_take) begin
            next_count = N'(S_IRQ);
          end else begin
            next_count = N'(S_HALT);
          end
        end
        N'(S_IRQ): begin
          // Unreachable without interrupt support, so reaching it is an error
          next_count  = N'(S_FETCH0);
          set_illegal = ~IRQ_ON;
        end
        default: begin
          // Execute steps 3..37
          if (END_MASK[counter_value]) begin
            terminal = 1'b1;
            if (irq_take) begin
              next_count = N'(S_IRQ);
            end else begin
              next_count = N'(S_FETCH0);
            end
          end else begin
            next_count = counter_value + N'(1);
          end
        end
      endcase
    end
  end

  // Retire pulse suppressed while frozen or being reset.
  assign instr_done = terminal & ~stall & ~rst;

  // State register and registered status flags; stall freezes all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_value <= N'(S_FETCH0);
      halted        <= 1'b0;
      illegal_op    <= 1'b0;
      irq_ack       <= 1'b0;
    end else if (stall) begin
      counter_value <= counter_value;
      halted        <= halted;
      illegal_op    <= illegal_op;
      irq_ack       <= irq_ack;
    end else begin
      counter_value <= next_count;
      halted        <= (next_count == N'(S_HALT));
      illegal_op    <= illegal_op | set_illegal;
      irq_ack       <= IRQ_ON & (next_count == N'(S_IRQ));
    end
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios followed by
// randomized stall/irq/opcode/reset traffic against an instruction-level model.
module tb_cu_sequencer;

  localparam int N   = 6;
  localparam int ST  = 40;
  localparam int OPW = 5;
`ifdef CU_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, stall, irq;
  logic [OPW-1:0] opcode;
  logic [N-1:0]   counter_value;
  logic [ST-1:0]  CPU_state;
  logic           instr_done, halted, illegal_op, irq_ack;

  cu_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .opcode        (opcode),
    .irq           (irq),
    .counter_value (counter_value),
    .CPU_state     (CPU_state),
    .instr_done    (instr_done),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .irq_ack       (irq_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction table: first execute step and number of execute steps (0 = unmapped)
  int op_start[32];
  int op_len[32];

  // Model: current state number, execute steps left after this one, sticky illegal
  int m_cnt;
  int m_left;
  bit m_ill;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check current outputs, advance model at posedge.
  task automatic step(input logic r, input logic s, input logic [OPW-1:0] op, input logic i);
    logic [ST-1:0] oh;
    @(negedge clk);
    rst = r; stall = s; opcode = op; irq = i;
    #1;
    oh = '0;
    oh[m_cnt] = 1'b1;
    chk("counter",    64'(counter_value), 64'(m_cnt));
    chk("cpu_state",  64'(CPU_state), 64'(oh));
    chk("instr_done", 64'(instr_done), 64'(!r && !s && m_cnt >= 3 && m_cnt <= 37 && m_left == 0));
    chk("halted",     64'(halted), 64'(m_cnt == 38));
    chk("illegal_op", 64'(illegal_op), 64'(m_ill));
    chk("irq_ack",    64'(irq_ack), 64'(m_cnt == 39));
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_left = 0; m_ill = 1'b0;
    end else if (!s) begin
      if (m_cnt == 0) m_cnt = 1;
      else if (m_cnt == 1) m_cnt = 2;
      else if (m_cnt == 2) begin
        if (op == 5'd14) m_cnt = 38;
        else if (op_len[op] > 0) begin
          m_cnt = op_start[op]; m_left = op_len[op] - 1;
        end else begin
          m_cnt = 0; m_ill = 1'b1;
        end
      end
      else if (m_cnt == 38) m_cnt = (IRQ_EN && i) ? 39 : 38;
      else if (m_cnt == 39) m_cnt = 0;
      else if (m_left == 0) m_cnt = (IRQ_EN && i) ? 39 : 0;
      else begin
        m_cnt++; m_left--;
      end
    end
    #1;
  endtask

  initial begin
    int halt_run;
    for (int k = 0; k < 32; k++) begin
      op_start[k] = 0; op_len[k] = 0;
    end
    op_start[0]  = 3;  op_len[0]  = 1;  // NOP
    op_start[1]  = 4;  op_len[1]  = 1;  // INC
    op_start[2]  = 5;  op_len[2]  = 2;  // ADD
    op_start[3]  = 7;  op_len[3]  = 2;  // SUB
    op_start[4]  = 9;  op_len[4]  = 2;  // AND
    op_start[5]  = 11; op_len[5]  = 2;  // OR
    op_start[6]  = 13; op_len[6]  = 3;  // LOAD
    op_start[7]  = 16; op_len[7]  = 3;  // STORE
    op_start[8]  = 19; op_len[8]  = 2;  // JMP
    op_start[9]  = 21; op_len[9]  = 2;  // JZ
    op_start[10] = 23; op_len[10] = 4;  // CALL
    op_start[11] = 27; op_len[11] = 3;  // RET
    op_start[12] = 30; op_len[12] = 8;  // MUL
    op_start[13] = 14; op_len[13] = 2;  // LDI

    // Test 1: reset held two cycles
    rst = 1'b1; stall = 1'b0; irq = 1'b0; opcode = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_counter",   64'(counter_value), 64'd0);
    chk("rst_cpu_state", 64'(CPU_state), 64'h1);
    chk("rst_done",      64'(instr_done), 64'd0);
    chk("rst_halted",    64'(halted), 64'd0);
    chk("rst_illegal",   64'(illegal_op), 64'd0);
    chk("rst_irq_ack",   64'(irq_ack), 64'd0);
    m_cnt = 0; m_left = 0; m_ill = 1'b0;

    // Test 2: ADD -> 0,1,2,5,6,0
    step(1'b0, 1'b0, 5'd2, 1'b0);
    step(1'b0, 1'b0, 5'd2, 1'b0);
    step(1'b0, 1'b0, 5'd2, 1'b0);
    chk("t2_start", 64'(counter_value), 64'd5);
    step(1'b0, 1'b0, 5'd2, 1'b0);
    chk("t2_term", 64'(counter_value), 64'd6);
    chk("t2_done_at6", 64'(instr_done), 64'd1);
    step(1'b0, 1'b0, 5'd2, 1'b0);
    chk("t2_back", 64'(counter_value), 64'd0);

    // Test 3: stall three cycles in FETCH1
    step(1'b0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 5'd0, 1'b0);
      chk("t3_hold", 64'(counter_value), 64'd1);
    end
    step(1'b0, 1'b0, 5'd0, 1'b0);
    chk("t3_resume", 64'(counter_value), 64'd2);
    step(1'b0, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0);

    // Test 4: unmapped opcode traps to FETCH0 and sets sticky illegal_op
    step(1'b0, 1'b0, 5'd20, 1'b0);
    step(1'b0, 1'b0, 5'd20, 1'b0);
    step(1'b0, 1'b0, 5'd20, 1'b0);
    chk("t4_state", 64'(counter_value), 64'd0);
    chk("t4_illegal", 64'(illegal_op), 64'd1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 5'd1, 1'b0);
    chk("t4_sticky", 64'(illegal_op), 64'd1);

    // Test 5: HALT, then reset out of it
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b0, 1'b0, 5'd14, 1'b0);
    step(1'b0, 1'b0, 5'd14, 1'b0);
    step(1'b0, 1'b0, 5'd14, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, OPW'($urandom_range(0, 31)), 1'b0);
      chk("t5_halted", 64'(halted), 64'd1);
    end
    step(1'b1, 1'b0, 5'd0, 1'b0);
    chk("t5_rst_state", 64'(counter_value), 64'd0);
    chk("t5_rst_halted", 64'(halted), 64'd0);

    // Test 6: irq held during MUL execute steps
    step(1'b0, 1'b0, 5'd12, 1'b0);
    step(1'b0, 1'b0, 5'd12, 1'b0);
    step(1'b0, 1'b0, 5'd12, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 5'd12, 1'b1);
    chk("t6_boundary", 64'(counter_value), IRQ_EN ? 64'd39 : 64'd0);
    chk("t6_ack", 64'(irq_ack), IRQ_EN ? 64'd1 : 64'd0);
    step(1'b0, 1'b0, 5'd0, 1'b0);
    chk("t6_after", 64'(counter_value), IRQ_EN ? 64'd0 : 64'd1);

    // Randomized traffic
    halt_run = 0;
    for (int k = 0; k < 3000; k++) begin
      logic           r, s, i;
      logic [OPW-1:0] op;
      int             sel;
      sel = $urandom_range(0, 99);
      if (sel < 84)      op = OPW'($urandom_range(0, 13));
      else if (sel < 92) op = 5'd14;
      else               op = OPW'($urandom_range(15, 31));
      s = ($urandom_range(0, 3) == 0);
      i = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 79) == 0) || (halt_run > 12);
      halt_run = (m_cnt == 38) ? halt_run + 1 : 0;
      step(r, s, op, i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
